// File: rtl/max7219_rx_emul.sv
// rtl/max7219_rx_emul.sv - MAX7219 serial responder with register file and daisy-chain output
//
// Device end of a MAX7219 3-wire link. CLK/DIN/LOAD are synchronised to clk,
// DIN is shifted on each CLK rise, and a LOAD rise commits the last 16 bits to
// a MAX7219-compatible register file.
//
// Ports:
//   clk, rst           system clock, synchronous active-high reset
//   i_max7219_clk      serial clock (asynchronous)
//   i_max7219_din      serial data, MSB first
//   i_max7219_load     load strobe, rising edge latches the frame
//   o_max7219_dout     daisy-chain output (shift bit 15, updated on CLK fall)
//   i_rd_digit         digit register index for the read port
//   o_rd_digit         registered digit read data (1-cycle latency)
//   o_decode_mode      register 0x9
//   o_intensity        register 0xA [3:0]
//   o_scan_limit       register 0xB [2:0]
//   o_shutdown_n       register 0xC [0]
//   o_display_test     register 0xF [0]
//   o_frame_valid      pulse when a full frame is latched
//   o_frame_addr       address nibble of last latched frame
//   o_frame_data       data byte of last latched frame
//   o_frame_err        pulse when LOAD rises with fewer than 16 bits shifted

module max7219_rx_emul #(
    parameter int G_SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_max7219_clk,
    input  logic       i_max7219_din,
    input  logic       i_max7219_load,
    output logic       o_max7219_dout,
    input  logic [2:0] i_rd_digit,
    output logic [7:0] o_rd_digit,
    output logic [7:0] o_decode_mode,
    output logic [3:0] o_intensity,
    output logic [2:0] o_scan_limit,
    output logic       o_shutdown_n,
    output logic       o_display_test,
    output logic       o_frame_valid,
    output logic [3:0] o_frame_addr,
    output logic [7:0] o_frame_data,
    output logic       o_frame_err
);

    localparam int INHIBIT = G_SYNC_STAGES + 1;

    logic [G_SYNC_STAGES-1:0] clk_sync;
    logic [G_SYNC_STAGES-1:0] din_sync;
    logic [G_SYNC_STAGES-1:0] load_sync;
    logic                     clk_hist;
    logic                     load_hist;
    logic [2:0]               inh_cnt;
    logic                     edge_en;
    logic                     clk_rise;
    logic                     clk_fall;
    logic                     load_rise;
    logic                     load_pend;
    logic [15:0]              shift;
    logic [4:0]               bit_cnt;
    logic [7:0]               digit [8];
    logic [2:0]               digit_idx;

    // Synchronisers, history flops and the post-reset edge inhibit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync  <= '0;
            din_sync  <= '0;
            load_sync <= '0;
            clk_hist  <= 1'b0;
            load_hist <= 1'b0;
            inh_cnt   <= 3'd0;
        end else begin
            clk_sync  <= {clk_sync[G_SYNC_STAGES-2:0], i_max7219_clk};
            din_sync  <= {din_sync[G_SYNC_STAGES-2:0], i_max7219_din};
            load_sync <= {load_sync[G_SYNC_STAGES-2:0], i_max7219_load};
            clk_hist  <= clk_sync[G_SYNC_STAGES-1];
            load_hist <= load_sync[G_SYNC_STAGES-1];
            if (inh_cnt != 3'(INHIBIT))
                inh_cnt <= inh_cnt + 3'd1;
        end
    end

    // Lines already high at reset release would otherwise look like rises
    // while the cleared chains fill up.
    assign edge_en   = (inh_cnt == 3'(INHIBIT));
    assign clk_rise  = edge_en &  clk_sync[G_SYNC_STAGES-1] & ~clk_hist;
    assign clk_fall  = edge_en & ~clk_sync[G_SYNC_STAGES-1] &  clk_hist;
    assign load_rise = edge_en &  load_sync[G_SYNC_STAGES-1] & ~load_hist;

    // addr 1..8 -> digit 0..7; addr 8 wraps 0-1 to 7 in three bits.
    assign digit_idx = shift[10:8] - 3'd1;

    // LOAD is acted on one cycle after detection so a CLK rise detected in the
    // same cycle has already landed in shift/bit_cnt.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_pend      <= 1'b0;
            shift          <= '0;
            bit_cnt        <= '0;
            o_max7219_dout <= 1'b0;
            o_decode_mode  <= '0;
            o_intensity    <= '0;
            o_scan_limit   <= '0;
            o_shutdown_n   <= 1'b0;
            o_display_test <= 1'b0;
            o_frame_valid  <= 1'b0;
            o_frame_err    <= 1'b0;
            o_frame_addr   <= '0;
            o_frame_data   <= '0;
            o_rd_digit     <= '0;
            for (int i = 0; i < 8; i++)
                digit[i] <= '0;
        end else begin
            load_pend     <= load_rise;
            o_frame_valid <= 1'b0;
            o_frame_err   <= 1'b0;
            o_rd_digit    <= digit[i_rd_digit];

            if (clk_rise) begin
                shift <= {shift[14:0], din_sync[G_SYNC_STAGES-1]};
                if (bit_cnt != 5'd16)
                    bit_cnt <= bit_cnt + 5'd1;
            end

            if (clk_fall)
                o_max7219_dout <= shift[15];

            if (load_pend) begin
                // A CLK rise in this cycle belongs to the next frame.
                bit_cnt <= clk_rise ? 5'd1 : 5'd0;
                if (bit_cnt < 5'd16) begin
                    o_frame_err <= 1'b1;
                end else begin
                    o_frame_valid <= 1'b1;
                    o_frame_addr  <= shift[11:8];
                    o_frame_data  <= shift[7:0];
                    case (shift[11:8])
                        4'h1, 4'h2, 4'h3, 4'h4,
                        4'h5, 4'h6, 4'h7, 4'h8: digit[digit_idx] <= shift[7:0];
                        4'h9:    o_decode_mode  <= shift[7:0];
                        4'hA:    o_intensity    <= shift[3:0];
                        4'hB:    o_scan_limit   <= shift[2:0];
                        4'hC:    o_shutdown_n   <= shift[0];
                        4'hF:    o_display_test <= shift[0];
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_max7219_rx_emul.sv
// tb/tb_max7219_rx_emul.sv - self-checking bench for max7219_rx_emul

module tb_max7219_rx_emul;

    localparam int G  = 2;
    localparam int HP = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b1;
    logic       din = 1'b0;
    logic       load = 1'b1;
    logic [2:0] rd_digit = 3'd0;
    logic       dout;
    logic [7:0] rd_data;
    logic [7:0] decode_mode;
    logic [3:0] intensity;
    logic [2:0] scan_limit;
    logic       shutdown_n;
    logic       display_test;
    logic       frame_valid;
    logic [3:0] frame_addr;
    logic [7:0] frame_data;
    logic       frame_err;

    max7219_rx_emul #(.G_SYNC_STAGES(G)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_max7219_clk  (sclk),
        .i_max7219_din  (din),
        .i_max7219_load (load),
        .o_max7219_dout (dout),
        .i_rd_digit     (rd_digit),
        .o_rd_digit     (rd_data),
        .o_decode_mode  (decode_mode),
        .o_intensity    (intensity),
        .o_scan_limit   (scan_limit),
        .o_shutdown_n   (shutdown_n),
        .o_display_test (display_test),
        .o_frame_valid  (frame_valid),
        .o_frame_addr   (frame_addr),
        .o_frame_data   (frame_data),
        .o_frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: bit history since reset, bits since last LOAD, register file.
    logic [7:0] m_digit [8];
    logic [7:0] m_decode;
    logic [3:0] m_int;
    logic [2:0] m_scan;
    logic       m_shut;
    logic       m_test;
    logic [3:0] m_addr;
    logic [7:0] m_data;
    bit         hist [$];
    bit         pend [$];

    typedef struct {
        logic [31:0] word;
        int          nbits;
        bit          exp_v;
        bit          exp_e;
        logic [3:0]  exp_addr;
        logic [7:0]  exp_data;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_digit[i] = '0;
        m_decode = '0; m_int = '0; m_scan = '0; m_shut = 1'b0; m_test = 1'b0;
        m_addr = '0; m_data = '0;
        hist.delete();
        pend.delete();
    endtask

    task automatic model_load(output bit v, output bit e);
        logic [15:0] w;
        v = 1'b0; e = 1'b0; w = '0;
        if (pend.size() < 16) begin
            e = 1'b1;
        end else begin
            v = 1'b1;
            for (int i = 0; i < 16; i++)
                w = {w[14:0], pend[pend.size() - 16 + i]};
            m_addr = w[11:8];
            m_data = w[7:0];
            if (w[11:8] >= 4'h1 && w[11:8] <= 4'h8) m_digit[int'(w[11:8]) - 1] = w[7:0];
            else if (w[11:8] == 4'h9) m_decode = w[7:0];
            else if (w[11:8] == 4'hA) m_int = w[3:0];
            else if (w[11:8] == 4'hB) m_scan = w[2:0];
            else if (w[11:8] == 4'hC) m_shut = w[0];
            else if (w[11:8] == 4'hF) m_test = w[0];
        end
        pend.delete();
    endtask

    // DOUT after a CLK fall is the bit shifted in 16 rises earlier.
    task automatic fall_and_check(input bit b);
        din = b;
        sclk = 1'b0;
        cyc(HP);
        chk("dout", 32'(dout), 32'((hist.size() >= 16) ? hist[hist.size() - 16] : 1'b0));
    endtask

    task automatic send_bit(input bit b);
        fall_and_check(b);
        sclk = 1'b1;
        hist.push_back(b);
        pend.push_back(b);
        cyc(HP);
    endtask

    task automatic send_word(input logic [31:0] w, input int n);
        for (int i = n - 1; i >= 0; i--)
            send_bit(w[i]);
    endtask

    task automatic check_regs();
        chk("decode_mode", 32'(decode_mode), 32'(m_decode));
        chk("intensity", 32'(intensity), 32'(m_int));
        chk("scan_limit", 32'(scan_limit), 32'(m_scan));
        chk("shutdown_n", 32'(shutdown_n), 32'(m_shut));
        chk("display_test", 32'(display_test), 32'(m_test));
        chk("frame_addr", 32'(frame_addr), 32'(m_addr));
        chk("frame_data", 32'(frame_data), 32'(m_data));
        for (int i = 0; i < 8; i++) begin
            rd_digit = 3'(i);
            cyc(1);
            chk("rd_digit", 32'(rd_data), 32'(m_digit[i]));
        end
    endtask

    // Raise LOAD (optionally together with a final CLK rise) and watch the pulses.
    task automatic do_load(input bit simul, input bit sb, output int nv, output int ne);
        int lat;
        bit ev, ee;
        if (simul) begin
            fall_and_check(sb);
            hist.push_back(sb);
            pend.push_back(sb);
            sclk = 1'b1;
        end
        load = 1'b1;
        lat = -1; nv = 0; ne = 0;
        for (int c = 1; c <= 12; c++) begin
            cyc(1);
            if ((frame_valid || frame_err) && lat < 0) lat = c;
            nv += int'(frame_valid);
            ne += int'(frame_err);
        end
        model_load(ev, ee);
        chk("valid_count", 32'(nv), 32'(ev));
        chk("err_count", 32'(ne), 32'(ee));
        chk("pulse_latency", 32'(lat), 32'(G + 2));
        load = 1'b0;
        cyc(HP);
        check_regs();
    endtask

    task automatic do_reset();
        int nv, ne;
        rst = 1'b1;
        cyc(5);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_shutdown_n", 32'(shutdown_n), 32'd0);
        chk("rst_frame_addr", 32'(frame_addr), 32'd0);
        chk("rst_frame_data", 32'(frame_data), 32'd0);
        chk("rst_rd_digit", 32'(rd_data), 32'd0);
        rst = 1'b0;
        model_reset();
        nv = 0; ne = 0;
        for (int c = 0; c < 10; c++) begin
            cyc(1);
            nv += int'(frame_valid);
            ne += int'(frame_err);
        end
        chk("post_rst_valid", 32'(nv), 32'd0);
        chk("post_rst_err", 32'(ne), 32'd0);
        load = 1'b0;
        cyc(HP);
        check_regs();
    endtask

    initial begin
        int nv, ne;
        tbl[0] = '{32'h0A07, 16, 1'b1, 1'b0, 4'hA, 8'h07};
        tbl[1] = '{32'h0ABC, 12, 1'b0, 1'b1, 4'hA, 8'h07};
        tbl[2] = '{32'h0C01, 16, 1'b1, 1'b0, 4'hC, 8'h01};
        tbl[3] = '{32'h0D3C, 16, 1'b1, 1'b0, 4'hD, 8'h3C};
        tbl[4] = '{32'h0903, 16, 1'b1, 1'b0, 4'h9, 8'h03};
        tbl[5] = '{32'h0000, 16, 1'b1, 1'b0, 4'h0, 8'h00};

        // Reset with CLK and LOAD held high.
        sclk = 1'b1;
        load = 1'b1;
        do_reset();

        for (int t = 0; t < 6; t++) begin
            send_word(tbl[t].word, tbl[t].nbits);
            do_load(1'b0, 1'b0, nv, ne);
            chk("tbl_valid", 32'(nv), 32'(tbl[t].exp_v));
            chk("tbl_err", 32'(ne), 32'(tbl[t].exp_e));
            chk("tbl_addr", 32'(frame_addr), 32'(tbl[t].exp_addr));
            chk("tbl_data", 32'(frame_data), 32'(tbl[t].exp_data));
            if (t == 0) chk("tbl_intensity", 32'(intensity), 32'h7);
            if (t == 2) chk("tbl_shutdown_n", 32'(shutdown_n), 32'h1);
        end

        // Digit sweep.
        for (int i = 0; i < 8; i++) begin
            send_word({16'h0, 4'h0, 4'(i + 1), 8'(8'h10 + i)}, 16);
            do_load(1'b0, 1'b0, nv, ne);
        end
        for (int i = 0; i < 8; i++) begin
            rd_digit = 3'(i);
            cyc(1);
            chk("sweep_digit", 32'(rd_data), 32'(8'h10 + i));
        end

        // Daisy chain: only the last 16 bits reach the register file.
        send_word(32'h0F01_0B05, 32);
        do_load(1'b0, 1'b0, nv, ne);
        chk("daisy_scan_limit", 32'(scan_limit), 32'd5);
        chk("daisy_display_test", 32'(display_test), 32'd0);

        // 16th CLK rise and LOAD rise in the same cycle.
        for (int i = 15; i >= 1; i--)
            send_bit(1'((32'h0B03 >> i) & 1));
        do_load(1'b1, 1'b1, nv, ne);
        chk("simul_valid", 32'(nv), 32'd1);
        chk("simul_scan_limit", 32'(scan_limit), 32'd3);

        // Reset mid-frame discards the partial bits.
        send_word(32'hA5, 8);
        do_reset();
        do_load(1'b0, 1'b0, nv, ne);
        chk("midrst_err", 32'(ne), 32'd1);

        // Randomised frames.
        for (int r = 0; r < 24; r++) begin
            int n;
            n = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 15)) : int'($urandom_range(16, 24));
            send_word($urandom, n);
            do_load(1'b0, 1'b0, nv, ne);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
